// File: rtl/riscv_exception_if.sv
// Execute-stage to exception-controller bundle: instruction/decode inputs
// and the trap-record handshake to the CSR unit.
interface riscv_exception_if #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned CAUSE_W = 4
);
  logic               i_riscv_exception_valid;
  logic [6:0]         i_riscv_exception_opcode;
  logic [XLEN-1:0]    i_riscv_exception_pc;
  logic [31:0]        i_riscv_exception_instr;
  logic [XLEN-1:0]    i_riscv_exception_icu_result;
  logic               i_riscv_exception_branch_taken;
  logic [2:0]         i_riscv_exception_load_sel;
  logic [1:0]         i_riscv_exception_store_sel;
  logic               i_riscv_exception_illegal;
  logic               i_riscv_exception_ecall;
  logic               i_riscv_exception_ebreak;
  logic [1:0]         i_riscv_exception_priv;
  logic               i_riscv_exception_ack;
  logic               o_riscv_exception_trap_req;
  logic [CAUSE_W-1:0] o_riscv_exception_cause;
  logic [XLEN-1:0]    o_riscv_exception_tval;
  logic [XLEN-1:0]    o_riscv_exception_epc;
  logic               o_riscv_exception_stall;
  logic               o_riscv_exception_flush;

  modport master (
    output i_riscv_exception_valid, i_riscv_exception_opcode, i_riscv_exception_pc,
           i_riscv_exception_instr, i_riscv_exception_icu_result,
           i_riscv_exception_branch_taken, i_riscv_exception_load_sel,
           i_riscv_exception_store_sel, i_riscv_exception_illegal,
           i_riscv_exception_ecall, i_riscv_exception_ebreak,
           i_riscv_exception_priv, i_riscv_exception_ack,
    input  o_riscv_exception_trap_req, o_riscv_exception_cause,
           o_riscv_exception_tval, o_riscv_exception_epc,
           o_riscv_exception_stall, o_riscv_exception_flush
  );

  modport slave (
    input  i_riscv_exception_valid, i_riscv_exception_opcode, i_riscv_exception_pc,
           i_riscv_exception_instr, i_riscv_exception_icu_result,
           i_riscv_exception_branch_taken, i_riscv_exception_load_sel,
           i_riscv_exception_store_sel, i_riscv_exception_illegal,
           i_riscv_exception_ecall, i_riscv_exception_ebreak,
           i_riscv_exception_priv, i_riscv_exception_ack,
    output o_riscv_exception_trap_req, o_riscv_exception_cause,
           o_riscv_exception_tval, o_riscv_exception_epc,
           o_riscv_exception_stall, o_riscv_exception_flush
  );
endinterface

// File: rtl/riscv_exception_ctrl.sv
// Registered exception detector: prioritises misalignment/illegal/ecall/ebreak,
// holds a trap record for the CSR unit, then stalls and flushes the pipeline.
module riscv_exception_ctrl #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned IALIGN       = 16,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CAUSE_W      = 4
) (
  input  logic                  i_riscv_exception_clk,
  input  logic                  i_riscv_exception_rst,
  riscv_exception_if.slave      bus
);
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, HOLD, FLUSH} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               trap_req_q, stall_q, flush_q;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic [XLEN-1:0]    tval_q, tval_d, epc_q;
  logic               exc_d;
  logic               inst_mis, load_mis, store_mis;
  logic [XLEN-1:0]    addr;
  logic [6:0]         opc;

  assign addr = bus.i_riscv_exception_icu_result;
  assign opc  = bus.i_riscv_exception_opcode;

  always_comb begin
    inst_mis  = 1'b0;
    load_mis  = 1'b0;
    store_mis = 1'b0;
    if ((opc == OP_JAL) || (opc == OP_JALR) ||
        ((opc == OP_BRANCH) && bus.i_riscv_exception_branch_taken))
      inst_mis = (IALIGN == 32) ? (addr[1:0] != 2'b00) : addr[0];
    // load_sel 111 is unused and never faults
    if ((opc == OP_LOAD) && (bus.i_riscv_exception_load_sel != 3'b111)) begin
      unique case (bus.i_riscv_exception_load_sel[1:0])
        2'b01:   load_mis = addr[0];
        2'b10:   load_mis = (addr[1:0] != 2'b00);
        2'b11:   load_mis = (addr[2:0] != 3'b000);
        default: load_mis = 1'b0;
      endcase
    end
    if (opc == OP_STORE) begin
      unique case (bus.i_riscv_exception_store_sel)
        2'b01:   store_mis = addr[0];
        2'b10:   store_mis = (addr[1:0] != 2'b00);
        2'b11:   store_mis = (addr[2:0] != 3'b000);
        default: store_mis = 1'b0;
      endcase
    end
  end

  always_comb begin
    exc_d   = bus.i_riscv_exception_valid;
    cause_d = '0;
    tval_d  = '0;
    if (inst_mis) begin
      cause_d = CAUSE_W'(0);
      tval_d  = addr;
    end else if (bus.i_riscv_exception_illegal) begin
      cause_d = CAUSE_W'(2);
      tval_d  = XLEN'(bus.i_riscv_exception_instr);
    end else if (bus.i_riscv_exception_ebreak) begin
      cause_d = CAUSE_W'(3);
      tval_d  = bus.i_riscv_exception_pc;
    end else if (bus.i_riscv_exception_ecall) begin
      unique case (bus.i_riscv_exception_priv)
        2'b00:   cause_d = CAUSE_W'(8);
        2'b01:   cause_d = CAUSE_W'(9);
        default: cause_d = CAUSE_W'(11);
      endcase
    end else if (load_mis) begin
      cause_d = CAUSE_W'(4);
      tval_d  = addr;
    end else if (store_mis) begin
      cause_d = CAUSE_W'(6);
      tval_d  = addr;
    end else begin
      exc_d = 1'b0;
    end
  end

  always_ff @(posedge i_riscv_exception_clk) begin
    if (i_riscv_exception_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      trap_req_q <= 1'b0;
      stall_q    <= 1'b0;
      flush_q    <= 1'b0;
      cause_q    <= '0;
      tval_q     <= '0;
      epc_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (exc_d) begin
          cause_q    <= cause_d;
          tval_q     <= tval_d;
          epc_q      <= bus.i_riscv_exception_pc;
          trap_req_q <= 1'b1;
          stall_q    <= 1'b1;
          state_q    <= HOLD;
        end
        HOLD: if (bus.i_riscv_exception_ack) begin
          trap_req_q <= 1'b0;
          flush_q    <= 1'b1;
          cnt_q      <= CNT_W'(FLUSH_CYCLES - 1);
          state_q    <= FLUSH;
        end
        FLUSH: if (cnt_q == '0) begin
          flush_q <= 1'b0;
          stall_q <= 1'b0;
          state_q <= IDLE;
        end else begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_riscv_exception_trap_req = trap_req_q;
  assign bus.o_riscv_exception_cause    = cause_q;
  assign bus.o_riscv_exception_tval     = tval_q;
  assign bus.o_riscv_exception_epc      = epc_q;
  assign bus.o_riscv_exception_stall    = stall_q;
  assign bus.o_riscv_exception_flush    = flush_q;
endmodule

// File: tb/tb_riscv_exception_ctrl.sv
// Directed bench for riscv_exception_ctrl: an IALIGN=16 instance (a) and an
// IALIGN=32 instance (b) share identical stimulus.
module tb_riscv_exception_ctrl;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  riscv_exception_if #(.XLEN(64), .CAUSE_W(4)) ifa ();
  riscv_exception_if #(.XLEN(64), .CAUSE_W(4)) ifb ();

  assign ifb.i_riscv_exception_valid        = ifa.i_riscv_exception_valid;
  assign ifb.i_riscv_exception_opcode       = ifa.i_riscv_exception_opcode;
  assign ifb.i_riscv_exception_pc           = ifa.i_riscv_exception_pc;
  assign ifb.i_riscv_exception_instr        = ifa.i_riscv_exception_instr;
  assign ifb.i_riscv_exception_icu_result   = ifa.i_riscv_exception_icu_result;
  assign ifb.i_riscv_exception_branch_taken = ifa.i_riscv_exception_branch_taken;
  assign ifb.i_riscv_exception_load_sel     = ifa.i_riscv_exception_load_sel;
  assign ifb.i_riscv_exception_store_sel    = ifa.i_riscv_exception_store_sel;
  assign ifb.i_riscv_exception_illegal      = ifa.i_riscv_exception_illegal;
  assign ifb.i_riscv_exception_ecall        = ifa.i_riscv_exception_ecall;
  assign ifb.i_riscv_exception_ebreak       = ifa.i_riscv_exception_ebreak;
  assign ifb.i_riscv_exception_priv         = ifa.i_riscv_exception_priv;
  assign ifb.i_riscv_exception_ack          = ifa.i_riscv_exception_ack;

  riscv_exception_ctrl #(.XLEN(64), .IALIGN(16), .FLUSH_CYCLES(2), .CAUSE_W(4)) dut_a (
    .i_riscv_exception_clk (clk),
    .i_riscv_exception_rst (rst),
    .bus                   (ifa.slave)
  );

  riscv_exception_ctrl #(.XLEN(64), .IALIGN(32), .FLUSH_CYCLES(2), .CAUSE_W(4)) dut_b (
    .i_riscv_exception_clk (clk),
    .i_riscv_exception_rst (rst),
    .bus                   (ifb.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    ifa.i_riscv_exception_valid        = 1'b0;
    ifa.i_riscv_exception_opcode       = 7'b0010011;
    ifa.i_riscv_exception_pc           = '0;
    ifa.i_riscv_exception_instr        = '0;
    ifa.i_riscv_exception_icu_result   = '0;
    ifa.i_riscv_exception_branch_taken = 1'b0;
    ifa.i_riscv_exception_load_sel     = 3'b000;
    ifa.i_riscv_exception_store_sel    = 2'b00;
    ifa.i_riscv_exception_illegal      = 1'b0;
    ifa.i_riscv_exception_ecall        = 1'b0;
    ifa.i_riscv_exception_ebreak       = 1'b0;
    ifa.i_riscv_exception_priv         = 2'b11;
    ifa.i_riscv_exception_ack          = 1'b0;
  endtask

  task automatic do_reset();
    clear();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // presents the currently staged fields for one cycle, then idles the inputs
  task automatic fire();
    ifa.i_riscv_exception_valid = 1'b1;
    step();
    clear();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_trap"},  64'(ifa.o_riscv_exception_trap_req), 64'd0);
    check({tag, "_cause"}, 64'(ifa.o_riscv_exception_cause),    64'd0);
    check({tag, "_tval"},  ifa.o_riscv_exception_tval,          64'd0);
    check({tag, "_epc"},   ifa.o_riscv_exception_epc,           64'd0);
    check({tag, "_stall"}, 64'(ifa.o_riscv_exception_stall),    64'd0);
    check({tag, "_flush"}, 64'(ifa.o_riscv_exception_flush),    64'd0);
  endtask

  initial begin
    clear();
    step();
    do_reset();
    check_all_zero("reset");

    // JALR to odd target
    ifa.i_riscv_exception_opcode     = OP_JALR;
    ifa.i_riscv_exception_pc         = 64'h100;
    ifa.i_riscv_exception_icu_result = 64'h8000_0001;
    fire();
    check("jalr_trap",  64'(ifa.o_riscv_exception_trap_req), 64'd1);
    check("jalr_cause", 64'(ifa.o_riscv_exception_cause),    64'd0);
    check("jalr_tval",  ifa.o_riscv_exception_tval,          64'h8000_0001);
    check("jalr_epc",   ifa.o_riscv_exception_epc,           64'h100);
    check("jalr_stall", 64'(ifa.o_riscv_exception_stall),    64'd1);
    check("jalr_b_trap", 64'(ifb.o_riscv_exception_trap_req), 64'd1);
    step();
    check("hold2_trap", 64'(ifa.o_riscv_exception_trap_req), 64'd1);
    check("hold2_tval", ifa.o_riscv_exception_tval,          64'h8000_0001);
    step();
    // HOLD cycle 3: ack plus a competing exception that must be ignored
    ifa.i_riscv_exception_ack     = 1'b1;
    ifa.i_riscv_exception_valid   = 1'b1;
    ifa.i_riscv_exception_illegal = 1'b1;
    ifa.i_riscv_exception_instr   = 32'hDEAD_BEEF;
    ifa.i_riscv_exception_pc      = 64'h300;
    step();
    ifa.i_riscv_exception_ack = 1'b0;
    check("ack_trap",  64'(ifa.o_riscv_exception_trap_req), 64'd0);
    check("ack_flush", 64'(ifa.o_riscv_exception_flush),    64'd1);
    check("ack_stall", 64'(ifa.o_riscv_exception_stall),    64'd1);
    check("ack_epc",   ifa.o_riscv_exception_epc,           64'h100);
    step();
    check("flush2_flush", 64'(ifa.o_riscv_exception_flush),    64'd1);
    check("flush2_trap",  64'(ifa.o_riscv_exception_trap_req), 64'd0);
    step();
    check("idle_flush", 64'(ifa.o_riscv_exception_flush),    64'd0);
    check("idle_stall", 64'(ifa.o_riscv_exception_stall),    64'd0);
    check("idle_trap",  64'(ifa.o_riscv_exception_trap_req), 64'd0);
    check("idle_cause", 64'(ifa.o_riscv_exception_cause),    64'd0);
    check("idle_tval",  ifa.o_riscv_exception_tval,          64'h8000_0001);
    step();
    clear();
    check("b2b_trap",  64'(ifa.o_riscv_exception_trap_req), 64'd1);
    check("b2b_cause", 64'(ifa.o_riscv_exception_cause),    64'd2);
    check("b2b_tval",  ifa.o_riscv_exception_tval,          64'hDEAD_BEEF);
    check("b2b_epc",   ifa.o_riscv_exception_epc,           64'h300);

    // IALIGN differences
    do_reset();
    ifa.i_riscv_exception_opcode       = OP_BRANCH;
    ifa.i_riscv_exception_branch_taken = 1'b1;
    ifa.i_riscv_exception_icu_result   = 64'h0000_1002;
    fire();
    check("br32_trap",  64'(ifb.o_riscv_exception_trap_req), 64'd1);
    check("br32_cause", 64'(ifb.o_riscv_exception_cause),    64'd0);
    check("br32_tval",  ifb.o_riscv_exception_tval,          64'h1002);
    check("br16_trap",  64'(ifa.o_riscv_exception_trap_req), 64'd0);
    do_reset();
    ifa.i_riscv_exception_opcode     = OP_BRANCH;
    ifa.i_riscv_exception_icu_result = 64'h0000_1002;
    fire();
    check("brnt_trap", 64'(ifb.o_riscv_exception_trap_req), 64'd0);
    do_reset();
    ifa.i_riscv_exception_opcode     = OP_JAL;
    ifa.i_riscv_exception_icu_result = 64'h0000_1002;
    fire();
    check("jal16_trap", 64'(ifa.o_riscv_exception_trap_req), 64'd0);

    // loads and stores
    do_reset();
    ifa.i_riscv_exception_opcode     = OP_LOAD;
    ifa.i_riscv_exception_load_sel   = 3'b011;
    ifa.i_riscv_exception_icu_result = 64'h1004;
    fire();
    check("ld_trap",  64'(ifa.o_riscv_exception_trap_req), 64'd1);
    check("ld_cause", 64'(ifa.o_riscv_exception_cause),    64'd4);
    check("ld_tval",  ifa.o_riscv_exception_tval,          64'h1004);
    do_reset();
    ifa.i_riscv_exception_opcode     = OP_STORE;
    ifa.i_riscv_exception_store_sel  = 2'b01;
    ifa.i_riscv_exception_icu_result = 64'h1001;
    fire();
    check("sh_cause", 64'(ifa.o_riscv_exception_cause), 64'd6);
    check("sh_tval",  ifa.o_riscv_exception_tval,       64'h1001);
    do_reset();
    ifa.i_riscv_exception_opcode     = OP_LOAD;
    ifa.i_riscv_exception_load_sel   = 3'b100;
    ifa.i_riscv_exception_icu_result = 64'h1003;
    fire();
    check("lbu_trap", 64'(ifa.o_riscv_exception_trap_req), 64'd0);
    ifa.i_riscv_exception_opcode     = OP_LOAD;
    ifa.i_riscv_exception_load_sel   = 3'b111;
    ifa.i_riscv_exception_icu_result = 64'h1003;
    fire();
    check("ld111_trap", 64'(ifa.o_riscv_exception_trap_req), 64'd0);
    ifa.i_riscv_exception_illegal = 1'b1;
    step();
    clear();
    check("novalid_trap", 64'(ifa.o_riscv_exception_trap_req), 64'd0);

    // priority
    ifa.i_riscv_exception_opcode     = OP_JAL;
    ifa.i_riscv_exception_icu_result = 64'h2001;
    ifa.i_riscv_exception_illegal    = 1'b1;
    fire();
    check("prio_cause", 64'(ifa.o_riscv_exception_cause), 64'd0);
    do_reset();
    ifa.i_riscv_exception_opcode = OP_SYSTEM;
    ifa.i_riscv_exception_ecall  = 1'b1;
    ifa.i_riscv_exception_priv   = 2'b01;
    ifa.i_riscv_exception_pc     = 64'h180;
    fire();
    check("ecallS_cause", 64'(ifa.o_riscv_exception_cause), 64'd9);
    check("ecallS_tval",  ifa.o_riscv_exception_tval,       64'd0);
    do_reset();
    ifa.i_riscv_exception_opcode = OP_SYSTEM;
    ifa.i_riscv_exception_ecall  = 1'b1;
    ifa.i_riscv_exception_priv   = 2'b10;
    fire();
    check("ecall10_cause", 64'(ifa.o_riscv_exception_cause), 64'd11);
    do_reset();
    ifa.i_riscv_exception_opcode     = OP_LOAD;
    ifa.i_riscv_exception_load_sel   = 3'b010;
    ifa.i_riscv_exception_icu_result = 64'h1002;
    ifa.i_riscv_exception_ebreak     = 1'b1;
    ifa.i_riscv_exception_pc         = 64'h200;
    fire();
    check("ebrk_cause", 64'(ifa.o_riscv_exception_cause), 64'd3);
    check("ebrk_tval",  ifa.o_riscv_exception_tval,       64'h200);

    // reset during FLUSH, then 1-cycle capture latency
    do_reset();
    ifa.i_riscv_exception_illegal = 1'b1;
    ifa.i_riscv_exception_instr   = 32'h1;
    fire();
    ifa.i_riscv_exception_ack = 1'b1;
    step();
    ifa.i_riscv_exception_ack = 1'b0;
    check("pre_rst_flush", 64'(ifa.o_riscv_exception_flush), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("rst_flush");
    ifa.i_riscv_exception_opcode     = OP_STORE;
    ifa.i_riscv_exception_store_sel  = 2'b11;
    ifa.i_riscv_exception_icu_result = 64'h1004;
    ifa.i_riscv_exception_pc         = 64'h400;
    fire();
    check("post_rst_trap",  64'(ifa.o_riscv_exception_trap_req), 64'd1);
    check("post_rst_cause", 64'(ifa.o_riscv_exception_cause),    64'd6);
    check("post_rst_tval",  ifa.o_riscv_exception_tval,          64'h1004);
    check("post_rst_epc",   ifa.o_riscv_exception_epc,           64'h400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/riscv_exception_ctrl.md
Name: riscv_exception_ctrl

Overview:
- Parametrised, registered successor to the combinational misalignment checker in the execute stage.
- Detects these exception sources:
  - instruction-address misaligned (IALIGN-selectable, covers C extension);
  - load misaligned and store misaligned;
  - illegal instruction, ecall, ebreak.
- Prioritises detected sources per the privileged spec.
- Captures cause/tval/epc into a trap record and presents it to the CSR unit with a valid/ack handshake.
- Stalls, then flushes, the pipeline for a programmable number of cycles.

Parameters:
- XLEN, 64, data/address width.
- IALIGN, 16, instruction alignment: 16 checks target bit 0 only; 32 checks bits [1:0].
- FLUSH_CYCLES, 2, cycles o_riscv_exception_flush stays high after ack; must be ≥1.
- CAUSE_W, 4, width of the cause code.

Ports:
- i_riscv_exception_clk  in  1  clock, rising edge.
- i_riscv_exception_rst  in  1  synchronous reset, active-high.
- i_riscv_exception_valid  in  1  instruction in stage is valid.
- i_riscv_exception_opcode  in  7  major opcode.
- i_riscv_exception_pc  in  XLEN  PC of the instruction.
- i_riscv_exception_instr  in  32  raw instruction bits.
- i_riscv_exception_icu_result  in  XLEN  branch/jump target or load/store effective address.
- i_riscv_exception_branch_taken  in  1  branch resolved taken.
- i_riscv_exception_load_sel  in  3  000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu.
- i_riscv_exception_store_sel  in  2  00 sb, 01 sh, 10 sw, 11 sd.
- i_riscv_exception_illegal  in  1  decoder flags illegal instruction.
- i_riscv_exception_ecall  in  1  ecall decoded.
- i_riscv_exception_ebreak  in  1  ebreak decoded.
- i_riscv_exception_priv  in  2  current privilege: 00 U, 01 S, 11 M.
- i_riscv_exception_ack  in  1  CSR unit accepted the trap.
- o_riscv_exception_trap_req  out  1  trap record valid.
- o_riscv_exception_cause  out  CAUSE_W  mcause code.
- o_riscv_exception_tval  out  XLEN  mtval value.
- o_riscv_exception_epc  out  XLEN  faulting PC.
- o_riscv_exception_stall  out  1  freeze upstream stages.
- o_riscv_exception_flush  out  1  flush younger instructions.

Behaviour:
- Reset: all outputs 0, state IDLE, flush counter 0.
- Detection is combinational; it is qualified by valid and is ignored outside IDLE.
- Instruction-address misaligned (cause 0), tval = icu_result:
  - applies to JAL/JALR unconditionally and to BRANCH only when branch_taken;
  - IALIGN=16: misaligned when icu_result[0]=1;
  - IALIGN=32: misaligned when icu_result[1:0]≠00.
- Load misaligned (cause 4), tval = icu_result:
  - LOAD opcode; h/hu check bit 0; w/wu check [1:0]; d checks [2:0]; b/bu never fault;
  - load_sel 111 → no fault.
- Store misaligned (cause 6), tval = icu_result:
  - same size rules using store_sel.
- Illegal instruction (cause 2), tval = instr.
- ebreak (cause 3), tval = pc.
- ecall, tval = 0:
  - cause 8 when priv=U, 9 when S, 11 when M;
  - priv=10 → cause 11.
- Priority, highest first: inst-misaligned, illegal, ebreak, ecall, load-misaligned, store-misaligned. Only the winner is recorded.
- FSM:
  - IDLE: a detected exception registers cause/tval/epc(=pc) at the clock edge, sets trap_req=1 and stall=1 → HOLD. Latency is 1 cycle from the valid input to trap_req.
  - HOLD: trap_req, cause, tval, epc stable; stall=1.
    - When ack=1, on that edge: trap_req→0, flush→1, counter loaded with FLUSH_CYCLES-1 → FLUSH.
    - ack while not in HOLD is ignored.
  - FLUSH: flush=1, stall=1; counter decrements each cycle.
    - When the counter is 0, next edge: flush→0, stall→0 → IDLE.
    - Total flush high = FLUSH_CYCLES cycles.
- Record registers retain the last trap after IDLE; only trap_req qualifies them.
- Back-to-back: an exception presented on the first IDLE cycle after FLUSH is captured normally.
- Reset mid-HOLD/FLUSH: next edge returns to IDLE with all outputs 0; the pending trap is lost.
- Non-exception opcodes, or valid=0: no state change.

Test Plan:
1. JALR, icu_result=0x8000_0001, IALIGN=16, valid=1 → next cycle trap_req=1, cause=0, tval=0x8000_0001, epc=pc, stall=1; hold until ack.
2. Taken branch to 0x...02 with IALIGN=32 → cause 0; the same branch not-taken → no trap. JAL to 0x...02 with IALIGN=16 → no trap.
3. LOAD sel=011 at addr 0x1004 → cause 4, tval=0x1004. Store sel=01 at 0x1001 → cause 6. lbu at 0x1003 → no trap.
4. illegal=1 plus JAL misaligned in the same cycle → cause 0 (priority). ecall with priv=01 → cause 9; ebreak with LOAD-misaligned → cause 3, tval=pc.
5. Ack at HOLD cycle 3, FLUSH_CYCLES=2 → trap_req falls, flush=1 for exactly 2 cycles, then stall=0. A new exception presented during HOLD or FLUSH is not captured.
6. Assert rst during FLUSH → next cycle all outputs 0, IDLE; a following exception is captured with 1-cycle latency.
